// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and fetch buffer entry type
package core_pkg;

    localparam int XLEN = 32;

    // Canonical RV32 no-op (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, parametrised on depth and entry type
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           full;
    logic           empty;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is only accepted when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage with request credits, buffer and redirect
module fetch_unit
    import core_pkg::*;
#(
    parameter int               XLEN       = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             stall_d_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ready_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             valid_d_o,
    output logic [31:0]      instr_d_o,
    output logic [XLEN-1:0]  pc_d_o,
    output logic [XLEN-1:0]  pc_plus4_d_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  pc_f;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    discard;

    logic             fire;
    logic             resp_keep;
    logic             credit_ok;

    logic [XLEN-1:0]  pq_head;
    logic [CW-1:0]    pq_count;

    fetch_entry_t     ib_push_data;
    fetch_entry_t     ib_head;
    logic [CW-1:0]    ib_count;
    logic             ib_pop;

    // Buffered entries plus outstanding requests never exceed the buffer size,
    // so every returning word is guaranteed a slot
    assign credit_ok   = ({1'b0, ib_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_o  = !rst && !redirect_i && credit_ok;
    assign imem_addr_o = pc_f;
    assign fire        = imem_req_o && imem_ready_i;

    // Responses belonging to requests issued before a redirect are dropped, as is
    // any response arriving in the redirect cycle itself
    assign resp_keep   = imem_rvalid_i && (discard == '0) && !redirect_i;

    assign ib_push_data = '{pc: pq_head, instr: imem_rdata_i};
    assign ib_pop       = valid_d_o && !stall_d_i && !redirect_i;

    // Address of every request still waiting for its response; stale entries
    // are flushed on redirect so discarded responses must not pop it
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pending_pc (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (fire),
        .push_data (pc_f),
        .pop       (resp_keep),
        .head      (pq_head),
        .count     (pq_count)
    );

    // Instruction buffer feeding decode
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (resp_keep),
        .push_data (ib_push_data),
        .pop       (ib_pop),
        .head      (ib_head),
        .count     (ib_count)
    );

    // Fetch PC, outstanding-request count and pending-discard count
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                pc_f    <= {redirect_pc_i[XLEN-1:2], 2'b00};
                discard <= inflight - CW'(imem_rvalid_i);
            end else begin
                if (fire) begin
                    pc_f <= pc_f + XLEN'(4);
                end
                if (imem_rvalid_i && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    assign valid_d_o    = (ib_count != '0);
    assign instr_d_o    = valid_d_o ? ib_head.instr : '0;
    assign pc_d_o       = valid_d_o ? ib_head.pc : '0;
    assign pc_plus4_d_o = valid_d_o ? (ib_head.pc + XLEN'(4)) : '0;

    // A response with nothing outstanding means the memory protocol was broken
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (inflight == '0)));

    // A kept response always has a matching pending address
    a_pending_pc_present: assert property (@(posedge clk) disable iff (rst)
        !(resp_keep && (pq_count == '0)));

endmodule
